// File: rtl/layer_activate.sv
// Adds a per-node bias to a captured layer vector and applies a saturating ReLU, one node per pass.
// Optional feature: define LAYER_ACTIVATE_LEAKY_RELU_EN to make negative sums leak at slope 1/8.
module layer_activate #(
    parameter int N  = 100,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [31:0]     num,
    input  logic [N*DW-1:0] d_in,
    output logic [31:0]     bias_addr,
    output logic            bias_rd,
    input  logic [DW-1:0]   bias_rdata,
    input  logic            bias_resp,
    output logic [N*DW-1:0] d_out,
    output logic            busy,
    output logic            done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        READ,
        APPLY,
        FINISH
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [31:0]       num_q, num_d;
    logic [31:0]       addr_q, addr_d;
    logic [DW-1:0]     bias_q, bias_d;
    logic [N*DW-1:0]   x_q, x_d;
    logic [N*DW-1:0]   dout_q, dout_d;

    logic [DW-1:0]     xElem;
    logic [DW:0]       sum;
    logic [DW-1:0]     sat;
    logic [DW-1:0]     act;

    // Activation datapath for the current element; the extra sum bit exposes overflow.
    always_comb begin
        xElem = x_q[idx_q*DW +: DW];
        sum   = {xElem[DW-1], xElem} + {bias_q[DW-1], bias_q};
        if (sum[DW] != sum[DW-1]) begin
            sat = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            sat = sum[DW-1:0];
        end
        if (sat[DW-1]) begin
`ifdef LAYER_ACTIVATE_LEAKY_RELU_EN
            act = $signed(sat) >>> 3;
`else
            act = '0;
`endif
        end else begin
            act = sat;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        num_d   = num_q;
        addr_d  = addr_q;
        bias_d  = bias_q;
        x_d     = x_q;
        dout_d  = dout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = d_in;
                    num_d   = num;
                    idx_d   = '0;
                    addr_d  = num * 32'(N);
                    state_d = ADDR;
                end
            end
            ADDR: begin
                state_d = READ;
            end
            READ: begin
                if (bias_resp) begin
                    bias_d  = bias_rdata;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                dout_d[idx_q*DW +: DW] = act;
                if (idx_q == IW'(N - 1)) begin
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    addr_d  = num_q * 32'(N) + 32'(idx_q) + 32'd1;
                    state_d = ADDR;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            num_q   <= '0;
            addr_q  <= '0;
            bias_q  <= '0;
            x_q     <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            addr_q  <= addr_d;
            bias_q  <= bias_d;
            x_q     <= x_d;
            dout_q  <= dout_d;
        end
    end

    // Control outputs decode straight from the state so reset clears them without a clock edge.
    assign bias_addr = addr_q;
    assign bias_rd   = (state_q == READ);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign d_out     = dout_q;

endmodule

// File: tb/tb_layer_activate.sv
// Scoreboard bench for layer_activate: stimulus queues expected results, a monitor checks on done/reads.
// Expected values for negative sums follow LAYER_ACTIVATE_LEAKY_RELU_EN when it is defined.
module tb_layer_activate;

    localparam int N       = 4;
    localparam int DW      = 32;
    localparam int TIMEOUT = 200;

`ifdef LAYER_ACTIVATE_LEAKY_RELU_EN
    localparam logic [31:0] NEG_ONE  = 32'hFFFFE000;
    localparam logic [31:0] NEG_HALF = 32'hFFFFF000;
    localparam logic [31:0] NEG_SAT  = 32'hF0000000;
`else
    localparam logic [31:0] NEG_ONE  = 32'h0;
    localparam logic [31:0] NEG_HALF = 32'h0;
    localparam logic [31:0] NEG_SAT  = 32'h0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [31:0]     num;
    logic [N*DW-1:0] d_in;
    logic [31:0]     bias_addr;
    logic            bias_rd;
    logic [DW-1:0]   bias_rdata;
    logic            bias_resp;
    logic [N*DW-1:0] d_out;
    logic            busy;
    logic            done;

    logic [DW-1:0]   biasMem [0:63];
    logic [31:0]     delayAddr;
    int              delayCycles;
    int              waitCnt;
    int              cycleCnt = 0;
    int              checkCount = 0;
    int              passCount = 0;
    int              busyLow = 0;
    logic            prevRd;
    logic [31:0]     prevAddr;

    typedef struct {
        logic [N*DW-1:0] dout;
        int              issueCycle;
        int              latency;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] addrQ[$];

    layer_activate #(.N(N), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num        (num),
        .d_in       (d_in),
        .bias_addr  (bias_addr),
        .bias_rd    (bias_rd),
        .bias_rdata (bias_rdata),
        .bias_resp  (bias_resp),
        .d_out      (d_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    // Bias memory model: answers in the same cycle unless the address is the one chosen to stall.
    always @(posedge clk or negedge reset) begin
        if (!reset) waitCnt <= 0;
        else        waitCnt <= (bias_rd && !bias_resp) ? waitCnt + 1 : 0;
    end
    assign bias_resp  = bias_rd && (waitCnt >= ((bias_addr == delayAddr) ? delayCycles : 0));
    assign bias_rdata = biasMem[bias_addr[5:0]];

    task automatic checkOutput(input string name, input logic [N*DW-1:0] actual,
                               input logic [N*DW-1:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic failEvent(input string name);
        checkCount++;
        $display("[TB] FAIL %s at cycle %0d", name, cycleCnt);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            prevRd = 1'b0;
        end else begin
            if (bias_rd && prevRd) checkOutput("bias_addr hold", bias_addr, prevAddr);
            if (bias_rd && bias_resp) begin
                if (addrQ.size() == 0) failEvent("unexpected bias read");
                else checkOutput("bias_addr", bias_addr, addrQ.pop_front());
            end
            if (done) begin
                if (expQ.size() == 0) begin
                    failEvent("unexpected done");
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("d_out", d_out, e.dout);
                    checkOutput("done latency", cycleCnt - e.issueCycle, e.latency);
                end
            end
            prevRd   = bias_rd;
            prevAddr = bias_addr;
        end
    end

    // Issues one start pulse; nAddr bias reads are expected, and a result only if pushResult is set.
    task automatic applyStimulus(input logic [31:0] numV, input logic [N*DW-1:0] vec,
                                 input logic [N*DW-1:0] expOut, input int latency,
                                 input int nAddr, input bit pushResult);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        num   = numV;
        d_in  = vec;
        for (int i = 0; i < nAddr; i++) addrQ.push_back(numV * N + i);
        if (pushResult) begin
            e.dout       = expOut;
            e.issueCycle = cycleCnt;
            e.latency    = latency;
            expQ.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input bit startOnDone);
        int n;
        n = 0;
        while (!done && n < TIMEOUT) begin
            if (!busy) busyLow++;
            @(negedge clk);
            n++;
        end
        if (!done) failEvent("timeout waiting for done");
        if (startOnDone) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        num         = '0;
        d_in        = '0;
        delayAddr   = 32'hFFFFFFFF;
        delayCycles = 0;
        for (int i = 0; i < 64; i++) biasMem[i] = '0;
        #2;
        checkOutput("reset d_out", d_out, '0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset bias_rd", bias_rd, 0);
        checkOutput("reset bias_addr", bias_addr, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        biasMem[8] = 32'h00008000; biasMem[9]  = 32'h00010000;
        biasMem[10] = 32'hFFFF0000; biasMem[11] = 32'h00000000;
        applyStimulus(2, {32'h00030000, 32'h00008000, 32'hFFFE0000, 32'h00010000},
                      {32'h00030000, NEG_HALF, NEG_ONE, 32'h00018000}, 13, N, 1'b1);
        waitDone(1'b0);

        biasMem[0] = 32'h00020000; biasMem[1] = 32'hFFFFFFFF;
        biasMem[2] = 32'h00000003; biasMem[3] = 32'h80000000;
        applyStimulus(0, {32'h80000000, 32'h00000005, 32'h80000000, 32'h7FFF0000},
                      {NEG_SAT, 32'h00000008, NEG_SAT, 32'h7FFFFFFF}, 13, N, 1'b1);
        waitDone(1'b0);

        biasMem[4] = 32'h00010000; biasMem[5] = 32'h00020000;
        biasMem[6] = 32'h00030000; biasMem[7] = 32'h00040000;
        delayAddr   = 32'd5;
        delayCycles = 5;
        applyStimulus(1, {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001},
                      {32'h00040004, 32'h00030003, 32'h00020002, 32'h00010001}, 18, N, 1'b1);
        waitDone(1'b0);
        delayAddr = 32'hFFFFFFFF;

        // Second start mid-run with new data, then a start coinciding with done: both ignored.
        applyStimulus(1, {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001},
                      {32'h00040004, 32'h00030003, 32'h00020002, 32'h00010001}, 13, N, 1'b1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        num   = 32'd2;
        d_in  = {4{32'h12345678}};
        @(negedge clk);
        start = 1'b0;
        waitDone(1'b1);
        @(negedge clk);
        checkOutput("idle after start on done", busy, 0);
        repeat (3 * N + 4) @(negedge clk);
        checkOutput("busy held during runs", busyLow, 0);

        for (int i = 12; i < 16; i++) biasMem[i] = 32'h00010000;
        applyStimulus(3, {4{32'h00000009}}, '0, 0, 2, 1'b0);
        for (int n = 0; n < TIMEOUT && bias_addr != 32'd14; n++) @(negedge clk);
        checkOutput("reached idx 2", bias_addr, 32'd14);
        reset = 1'b0;
        #1;
        checkOutput("abort d_out", d_out, '0);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort done", done, 0);
        checkOutput("abort bias_rd", bias_rd, 0);
        checkOutput("abort bias_addr", bias_addr, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3 * N + 4) @(negedge clk);
        applyStimulus(3, {4{32'h00000001}}, {4{32'h00010001}}, 13, N, 1'b1);
        waitDone(1'b0);
        repeat (4) @(negedge clk);

        checkOutput("result queue drained", expQ.size(), 0);
        checkOutput("address queue drained", addrQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
